// File: rtl/fifo_psram_lbuf_ctrl.sv
// Ping-pong line buffer controller: fetches 64-word pSRAM bursts into a free half of the
// 128x32 write / 256x16 read RAM and streams 16-bit pixels out of the full half.
module fifo_psram_lbuf_ctrl #(
    parameter int LINE_PIX = 1920
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       line_start,
    output logic       burst_req,
    input  logic       burst_ack,
    input  logic       wr_vld,
    output logic       cew,
    output logic [6:0] aw,
    input  logic       pix_req,
    output logic       pix_rdy,
    output logic       cer,
    output logic [7:0] ar,
    output logic       pix_vld,
    output logic       line_done,
    output logic       underrun
);

    localparam logic [15:0] LINE_BURSTS = 16'(LINE_PIX / 128);
    localparam logic [15:0] LINE_PIXELS = 16'(LINE_PIX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  full_reg;
    logic        wr_half_reg;
    logic [5:0]  wr_cnt_reg;
    logic        rd_half_reg;
    logic [6:0]  rd_cnt_reg;
    logic [15:0] bursts_left_reg;
    logic [15:0] pix_left_reg;
    logic        underrun_reg;
    logic        pix_vld_reg;
    logic        line_done_reg;

    logic        fill_done;
    logic        rd_done;

    assign fill_done = (state_reg == FILL) && wr_vld && (wr_cnt_reg == 6'd63);
    assign rd_done   = cer && (rd_cnt_reg == 7'd127);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; line_start overrides everything, including an open burst
    always_comb begin
        state_next = state_reg;
        if (line_start) begin
            state_next = REQ;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                REQ: begin
                    if (bursts_left_reg == 16'd0) begin
                        state_next = IDLE;
                    end else if (burst_req && burst_ack) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        state_next = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs: all driven from registered state plus the same-cycle strobes
    always_comb begin
        burst_req = (state_reg == REQ) && (bursts_left_reg != 16'd0) && !full_reg[wr_half_reg];
        cew       = (state_reg == FILL) && wr_vld;
        aw        = {wr_half_reg, wr_cnt_reg};
        pix_rdy   = full_reg[rd_half_reg] && (pix_left_reg != 16'd0);
        cer       = pix_req && pix_rdy;
        ar        = {rd_half_reg, rd_cnt_reg};
    end

    // Each half flag is set by its fill and cleared by its last read; the writer never
    // targets a full half, so set and clear on the same bit are mutually exclusive.
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                full_reg[gi] <= 1'b0;
            end else if (line_start) begin
                full_reg[gi] <= 1'b0;
            end else if (fill_done && (wr_half_reg == 1'(gi))) begin
                full_reg[gi] <= 1'b1;
            end else if (rd_done && (rd_half_reg == 1'(gi))) begin
                full_reg[gi] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_half_reg     <= 1'b0;
            wr_cnt_reg      <= 6'd0;
            rd_half_reg     <= 1'b0;
            rd_cnt_reg      <= 7'd0;
            bursts_left_reg <= 16'd0;
            pix_left_reg    <= 16'd0;
            underrun_reg    <= 1'b0;
        end else if (line_start) begin
            wr_half_reg     <= 1'b0;
            wr_cnt_reg      <= 6'd0;
            rd_half_reg     <= 1'b0;
            rd_cnt_reg      <= 7'd0;
            bursts_left_reg <= LINE_BURSTS;
            pix_left_reg    <= LINE_PIXELS;
            underrun_reg    <= 1'b0;
        end else begin
            if (cew) begin
                wr_cnt_reg <= wr_cnt_reg + 6'd1;
            end
            if (fill_done) begin
                wr_half_reg     <= ~wr_half_reg;
                bursts_left_reg <= bursts_left_reg - 16'd1;
            end
            if (cer) begin
                rd_cnt_reg   <= rd_cnt_reg + 7'd1;
                pix_left_reg <= pix_left_reg - 16'd1;
            end
            if (rd_done) begin
                rd_half_reg <= ~rd_half_reg;
            end
            if (pix_req && !pix_rdy) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    // pix_vld tracks the one-cycle RAM read latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_vld_reg   <= 1'b0;
            line_done_reg <= 1'b0;
        end else begin
            pix_vld_reg   <= cer;
            line_done_reg <= cer && (pix_left_reg == 16'd1);
        end
    end

    assign pix_vld   = pix_vld_reg;
    assign line_done = line_done_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_fifo_psram_lbuf_ctrl.sv
// Randomized bench: a line-level model (bursts filled, pixels read) predicts every output,
// and a RAM model checks that pixels come out in pSRAM word order, low halfword first.
module tb_fifo_psram_lbuf_ctrl;

    localparam int LP = 1920;
    localparam int NB = LP / 128;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       line_start = 1'b0;
    logic       burst_ack = 1'b0;
    logic       wr_vld = 1'b0;
    logic       pix_req = 1'b0;
    logic       burst_req, cew, pix_rdy, cer, pix_vld, line_done, underrun;
    logic [6:0] aw;
    logic [7:0] ar;

    logic [31:0] wdata = 32'd0;
    logic [31:0] mem [128];
    logic [15:0] rdq;

    int total = 0;
    int bad = 0;

    // Line-level model state
    int   m_total = 0;
    int   m_done = 0;
    int   m_words = 0;
    int   m_reads = 0;
    int   m_flush = 0;
    bit   m_inb = 0;
    bit   m_und = 0;
    bit   m_vld = 0;
    bit   m_ldone = 0;
    logic [15:0] m_pix = 16'd0;
    logic [15:0] key = 16'd0;

    int c_vld = 0;
    int c_done = 0;
    int c_acks = 0;

    always #5 clk = ~clk;

    fifo_psram_lbuf_ctrl #(.LINE_PIX(LP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .line_start(line_start),
        .burst_req (burst_req),
        .burst_ack (burst_ack),
        .wr_vld    (wr_vld),
        .cew       (cew),
        .aw        (aw),
        .pix_req   (pix_req),
        .pix_rdy   (pix_rdy),
        .cer       (cer),
        .ar        (ar),
        .pix_vld   (pix_vld),
        .line_done (line_done),
        .underrun  (underrun)
    );

    always @(posedge clk) begin
        if (cew) mem[aw] <= wdata;
        if (cer) rdq <= ar[0] ? mem[ar[7:1]][31:16] : mem[ar[7:1]][15:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int n);
        return {16'(2 * n + 1) ^ key, 16'(2 * n) ^ key};
    endfunction

    // A half is readable while fewer pixels were read than have been filled
    function automatic bit exp_rdy();
        return m_reads < m_done * 128;
    endfunction

    // Request while between bursts, bursts remain, and fewer than two halves hold unread data
    function automatic bit exp_req();
        return !m_inb && (m_done < m_total) && ((m_done - m_reads / 128) < 2);
    endfunction

    task automatic step(input bit ls, input bit ack, input bit wv, input bit pr);
        bit         e_rdy, e_req, e_cew, e_cer;
        logic [6:0] e_aw;
        line_start = ls;
        burst_ack  = ack;
        wr_vld     = wv;
        pix_req    = pr;
        wdata      = word(m_done * 64 + m_words);
        @(negedge clk);
        e_rdy = exp_rdy();
        e_req = exp_req();
        e_cew = wv && m_inb;
        e_cer = pr && e_rdy;
        e_aw  = {m_done[0], m_inb ? m_words[5:0] : 6'd0};
        check("burst_req", burst_req, e_req);
        check("pix_rdy", pix_rdy, e_rdy);
        check("cew", cew, e_cew);
        check("aw", aw, e_aw);
        check("cer", cer, e_cer);
        check("ar", ar, m_reads[7:0]);
        check("pix_vld", pix_vld, m_vld);
        check("line_done", line_done, m_ldone);
        check("underrun", underrun, m_und);
        if (m_vld) check("pixel", rdq, m_pix);
        if (pix_vld) c_vld++;
        if (line_done) c_done++;
        if (burst_req && ack) c_acks++;

        m_vld   = e_cer;
        m_ldone = e_cer && (m_reads == LP - 1);
        m_pix   = 16'(m_reads) ^ key;
        if (wv && !m_inb && m_flush > 0) m_flush--;
        if (ls) begin
            if (m_inb) m_flush = 64 - m_words - (wv ? 1 : 0);
            m_total = NB;
            m_done  = 0;
            m_words = 0;
            m_inb   = 0;
            m_reads = 0;
            m_und   = 0;
            key     = 16'($urandom);
        end else begin
            if (e_cew) begin
                m_words++;
                if (m_words == 64) begin
                    m_inb   = 0;
                    m_words = 0;
                    m_done++;
                    $display("burst %0d filled, pixels read %0d", m_done, m_reads);
                end
            end
            if (e_req && ack) begin
                m_inb   = 1;
                m_words = 0;
            end
            if (e_cer) m_reads++;
            if (pr && !e_rdy) m_und = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int ack_dly, input int wv_pct, input int pr_pct, input bit gate,
                            input bit spur, input int stall, input int abort_at);
        int cyc = 0;
        int wait_cnt = 0;
        bit ls, ack, wv, pr;
        step(1, 0, 0, 0);
        c_vld = 0; c_done = 0; c_acks = 0;
        while (!(m_reads == LP && !m_vld && !m_ldone) && cyc < 20000) begin
            ls = 0;
            if (abort_at >= 0 && m_inb && m_done == 0 && m_words == abort_at) begin
                ls = 1;
                abort_at = -1;
            end
            ack = 0;
            if (!ls && exp_req() && m_flush == 0) begin
                if (wait_cnt >= ack_dly) begin
                    ack = 1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (m_inb || m_flush > 0) wv = ($urandom % 100) < wv_pct;
            else wv = spur && ($urandom % 2 == 0);
            if (cyc < stall) pr = 0;
            else pr = (($urandom % 100) < pr_pct) && (!gate || exp_rdy());
            step(ls, ack, wv, pr);
            if (ls) begin
                c_vld = 0; c_done = 0; c_acks = 0; wait_cnt = 0;
            end
            cyc++;
        end
        check("line_timeout", 32'(cyc < 20000), 1);
        check("vld_count", c_vld, LP);
        check("done_count", c_done, 1);
        check("burst_count", c_acks, NB);
        $display("line: ack_dly=%0d cycles=%0d pix_vld=%0d bursts=%0d underrun=%0d",
                 ack_dly, cyc, c_vld, c_acks, m_und);
        repeat (4) step(0, 0, spur, 0);
    endtask

    initial begin
        repeat (3) step(0, 0, 0, 0);
        rstn = 1'b1;
        step(0, 0, 1, 1);
        run_line(0, 100, 100, 1, 0, 0, -1);
        run_line(100, 100, 100, 0, 0, 0, -1);
        run_line(0, 100, 100, 1, 0, 400, -1);
        run_line(0, 70, 80, 1, 1, 0, -1);
        run_line(0, 100, 50, 1, 0, 0, 20);
        run_line(3, 60, 70, 1, 1, 0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_psram_lbuf_ctrl.md
# fifo_psram_lbuf_ctrl

Single-clock ping-pong controller for the pSRAM line buffer, a 128 x 32-bit write / 256 x 16-bit read embedded RAM, in the MIPI-to-video pSRAM path. It requests 64-word pSRAM bursts into whichever buffer half is free and generates the buffer write address and enable. It also serves 16-bit pixels to the video timing side from whichever half is full, so one video line streams through the buffer without gaps. Data buses go straight between pSRAM and RAM; this block drives only the addresses, enables and flow control.

## Interface
- LINE_PIX, 1920, pixels per line; must be a multiple of 128 and at most 65535
- clk  in  1  single clock; the RAM read and write ports both run on clk
- rstn  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse that starts or restarts a line
- burst_req  out  1  requests one 64 x 32-bit pSRAM burst; held high until burst_ack
- burst_ack  in  1  pSRAM accepts the request
- wr_vld  in  1  one 32-bit burst word is present on the RAM write data this cycle
- cew  out  1  RAM write enable
- aw  out  7  RAM write address
- pix_req  in  1  video side consumes one pixel this cycle
- pix_rdy  out  1  a full half is available for reading
- cer  out  1  RAM read enable
- ar  out  8  RAM read address
- pix_vld  out  1  RAM read data valid, one cycle after cer
- line_done  out  1  one-cycle pulse after the last pixel of the line is read
- underrun  out  1  sticky: pix_req arrived while pix_rdy was low

## Operation
- Buffer halves: half h occupies aw[6]=h (words 0..63) and ar[7]=h (pixels 0..127). Word k maps to ar 2k (dw[15:0]) and 2k+1 (dw[31:16]).
- State:
  - full[1:0] flags
  - wr_half, wr_cnt[5:0]
  - rd_half, rd_cnt[6:0]
  - bursts_left[15:0], pix_left[15:0]
  - fetch FSM
- Fetch FSM states: IDLE, REQ, FILL.
  - IDLE -> REQ on line_start.
  - REQ: burst_req = (bursts_left != 0) & !full[wr_half]. When burst_req & burst_ack, go to FILL.
  - FILL:
    - cew = wr_vld; aw = {wr_half, wr_cnt}.
    - Each wr_vld increments wr_cnt.
    - On the wr_vld with wr_cnt == 63: set full[wr_half], toggle wr_half, decrement bursts_left, go to REQ.
  - REQ with bursts_left == 0 -> IDLE.
- wr_vld outside FILL is ignored: cew stays 0 and no counters change.
- Read side:
  - pix_rdy = full[rd_half] & (pix_left != 0).
  - cer = pix_req & pix_rdy; ar = {rd_half, rd_cnt}.
  - On each cer: rd_cnt++, pix_left--.
  - On the cer with rd_cnt == 127: clear full[rd_half] and toggle rd_half.
  - On the cer with pix_left == 1: line_done pulses the next cycle.
- pix_req & !pix_rdy sets underrun and performs no read. underrun clears only on line_start or reset.
- line_start, in any state and including mid-burst:
  - clears full, wr_cnt, rd_cnt, wr_half, rd_half and underrun;
  - loads bursts_left = LINE_PIX/128 and pix_left = LINE_PIX;
  - sends the FSM to REQ.
  - Any remaining words of an aborted burst arrive while the FSM is in REQ and are dropped. The pSRAM side must finish or flush its burst before it acks again.
- Simultaneous events:
  - Fill completion on one half and read completion on the other in the same cycle both take effect.
  - A set and a clear of the same full bit cannot coincide, because the writer only fills a half whose flag is clear.

## Timing
- Reset values: burst_req 0, cew 0, aw 0, cer 0, ar 0, pix_rdy 0, pix_vld 0, line_done 0, underrun 0, FSM IDLE.
- burst_req is registered; it rises the cycle after line_start.
- cew and aw are combinational from wr_vld and registered state, so write latency is zero.
- full is set at the edge after the last write. pix_rdy rises that same cycle, so the first read is never in the same cycle as the last write of that half.
- cer and ar are combinational from pix_req; pix_vld = cer delayed by 1 cycle, matching the unregistered RAM output.
- Throughput: 1 pixel per clk sustained when the writer keeps ahead, because full[~rd_half] is set before rd_cnt wraps.

## Test plan
- Reset, then line_start with LINE_PIX=256 and bursts acked immediately, 64 contiguous wr_vld each -> 2 bursts; aw runs 0..63 then 64..127; pix_rdy high after the first fill; 256 reads with ar 0..255; line_done exactly 1 cycle after the last cer.
- Continuous pix_req from the first pix_rdy with burst_ack delayed 100 cycles -> underrun=1 at the first pix_req with pix_rdy=0; no cer during the gap; reads resume at ar=128.
- Reads stalled, writer fills both halves -> burst_req stays 0 until the read at ar=127 clears full[0]; the next fill writes aw 0..63.
- wr_vld pulses while in REQ -> cew=0 and aw unchanged.
- line_start mid-FILL at wr_cnt=20 -> flags and counters reset; burst_req reasserts the next cycle; underrun cleared.
- LINE_PIX=1920, random wr_vld/pix_req gaps -> exactly 15 bursts and 1920 pix_vld; pixel data order matches pSRAM words low halfword first.
